// File: rtl/axis_layer_sequencer_if.sv
// rtl/axis_layer_sequencer_if.sv - command and stream handshake bundle for the layer sequencer
interface axis_layer_sequencer_if #(
  parameter int ITR_W = 16
) ();
  logic             s_cmd_valid;
  logic             s_cmd_ready;
  logic [ITR_W-1:0] s_cmd_itr;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic             s_axis_is_cfg;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;

  modport slave (
    input  s_cmd_valid, s_cmd_itr,
    input  s_axis_tvalid, s_axis_tlast, s_axis_is_cfg,
    input  m_axis_tready,
    output s_cmd_ready, s_axis_tready,
    output m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s_cmd_valid, s_cmd_itr,
    output s_axis_tvalid, s_axis_tlast, s_axis_is_cfg,
    output m_axis_tready,
    input  s_cmd_ready, s_axis_tready,
    input  m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_layer_sequencer.sv
// rtl/axis_layer_sequencer.sv - per-layer valid/ready gate between input pipe and conv engine
module axis_layer_sequencer #(
  parameter int ITR_W   = 16,
  parameter int BEAT_W  = 24,
  parameter int TIMEOUT = 1048576
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_layer_sequencer_if.slave bus,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [BEAT_W-1:0]     beat_count,
  output logic [BEAT_W-1:0]     cfg_count,
  output logic [ITR_W-1:0]      itr_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] TIMEOUT_V = IDLE_W'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [ITR_W-1:0]  itr_total;
  logic [IDLE_W-1:0] idle_cnt;
  logic              gate;
  logic              beat;
  logic              cmd_fire;
  logic              last_itr;
  logic              wd_expire;

  // Gate comes straight from the state register so the datapath sees no extra latency.
  assign gate      = (state == RUN);
  assign beat      = gate && bus.s_axis_tvalid && bus.m_axis_tready;
  assign cmd_fire  = (state == IDLE) && bus.s_cmd_valid;
  assign last_itr  = beat && bus.s_axis_tlast && (itr_count == itr_total - ITR_W'(1));
  assign wd_expire = (TIMEOUT != 0) && gate && !beat &&
                     ((idle_cnt + IDLE_W'(1)) == TIMEOUT_V);

  assign bus.m_axis_tvalid = gate && bus.s_axis_tvalid;
  assign bus.s_axis_tready = gate && bus.m_axis_tready;
  assign bus.m_axis_tlast  = gate && bus.s_axis_tlast;
  assign bus.s_cmd_ready   = (state == IDLE);
  assign busy              = (state != IDLE);
  assign done              = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = (bus.s_cmd_itr == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort outranks completion and timeout.
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_itr) begin
          state_nxt = DONE;
        end else if (wd_expire) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      itr_total   <= '0;
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
      beat_count  <= '0;
      cfg_count   <= '0;
      itr_count   <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        itr_total   <= bus.s_cmd_itr;
        idle_cnt    <= '0;
        err_timeout <= 1'b0;
        beat_count  <= '0;
        cfg_count   <= '0;
        itr_count   <= '0;
      end else if (gate) begin
        // A beat in an abort cycle has already crossed the gate, so it is still counted.
        if (beat) begin
          idle_cnt <= '0;
          if (beat_count != '1) begin
            beat_count <= beat_count + BEAT_W'(1);
          end
          if (bus.s_axis_is_cfg && (cfg_count != '1)) begin
            cfg_count <= cfg_count + BEAT_W'(1);
          end
          if (bus.s_axis_tlast) begin
            itr_count <= itr_count + ITR_W'(1);
          end
        end else if (TIMEOUT != 0) begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
        if (wd_expire && !abort) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_layer_sequencer.sv
// tb/tb_axis_layer_sequencer.sv - randomized and directed checks of axis_layer_sequencer
module tb_axis_layer_sequencer;
  localparam int ITR_W     = 16;
  localparam int BEAT_W    = 24;
  localparam int TIMEOUT   = 16;
  localparam int BEAT_MAX  = (1 << BEAT_W) - 1;

  logic aclk = 1'b0;
  logic areset;
  logic abort;
  logic busy;
  logic done;
  logic err_timeout;
  logic [BEAT_W-1:0] beat_count;
  logic [BEAT_W-1:0] cfg_count;
  logic [ITR_W-1:0]  itr_count;

  always #5 aclk = ~aclk;

  axis_layer_sequencer_if #(.ITR_W(ITR_W)) bus ();

  axis_layer_sequencer #(
    .ITR_W(ITR_W), .BEAT_W(BEAT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .abort(abort),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .beat_count(beat_count), .cfg_count(cfg_count), .itr_count(itr_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference: layer progress tracked as remaining iterations plus one-cycle done/error tails.
  bit m_run, m_done, m_errs, m_errf;
  int m_todo, m_beats, m_cfgs, m_itrs, m_idle;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit b;
    if (areset) begin
      m_run = 0; m_done = 0; m_errs = 0; m_errf = 0;
      m_todo = 0; m_beats = 0; m_cfgs = 0; m_itrs = 0; m_idle = 0;
      return;
    end
    if (m_done || m_errs) begin
      m_done = 0; m_errs = 0;
    end else if (!m_run) begin
      if (bus.s_cmd_valid) begin
        m_beats = 0; m_cfgs = 0; m_itrs = 0; m_idle = 0; m_errf = 0;
        if (bus.s_cmd_itr == 0) m_done = 1;
        else begin
          m_run  = 1;
          m_todo = int'(bus.s_cmd_itr);
        end
      end
    end else begin
      b = bus.s_axis_tvalid && bus.m_axis_tready;
      if (b) begin
        if (m_beats < BEAT_MAX) m_beats++;
        if (bus.s_axis_is_cfg) m_cfgs++;
        m_idle = 0;
        if (bus.s_axis_tlast) begin
          m_itrs++;
          m_todo--;
        end
      end else begin
        m_idle++;
      end
      if (abort) m_run = 0;
      else if (b && bus.s_axis_tlast && m_todo == 0) begin
        m_run = 0; m_done = 1;
      end else if (!b && m_idle == TIMEOUT) begin
        m_run = 0; m_errs = 1; m_errf = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    chk("m_tvalid", 32'(bus.m_axis_tvalid), 32'(m_run && bus.s_axis_tvalid));
    chk("s_tready", 32'(bus.s_axis_tready), 32'(m_run && bus.m_axis_tready));
    chk("m_tlast", 32'(bus.m_axis_tlast), 32'(m_run && bus.s_axis_tlast));
    chk("cmd_ready", 32'(bus.s_cmd_ready), 32'(!(m_run || m_done || m_errs)));
    chk("busy", 32'(busy), 32'(m_run || m_done || m_errs));
    chk("done", 32'(done), 32'(m_done));
    chk("err_timeout", 32'(err_timeout), 32'(m_errf));
    chk("beat_count", 32'(beat_count), m_beats);
    chk("cfg_count", 32'(cfg_count), m_cfgs);
    chk("itr_count", 32'(itr_count), m_itrs);
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic quiet();
    bus.s_cmd_valid   = 0;
    bus.s_cmd_itr     = '0;
    bus.s_axis_tvalid = 0;
    bus.s_axis_tlast  = 0;
    bus.s_axis_is_cfg = 0;
    bus.m_axis_tready = 0;
    abort             = 0;
  endtask

  task automatic send_cmd(int itr);
    bus.s_cmd_valid = 1;
    bus.s_cmd_itr   = ITR_W'(itr);
    tick();
    bus.s_cmd_valid = 0;
  endtask

  initial begin
    int nb, ncfg, dens;
    areset = 1;
    quiet();
    m_run = 0; m_done = 0; m_errs = 0; m_errf = 0;
    m_todo = 0; m_beats = 0; m_cfgs = 0; m_itrs = 0; m_idle = 0;
    tick();
    areset = 0;
    chk("rst_cmd_ready", 32'(bus.s_cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_beat_count", 32'(beat_count), 0);

    // 3 iterations of 4 beats, engine always ready
    send_cmd(3);
    bus.s_axis_tvalid = 1;
    bus.m_axis_tready = 1;
    for (int b = 0; b < 12; b++) begin
      bus.s_axis_tlast = (b % 4 == 3);
      tick();
    end
    bus.s_axis_tlast = 0;
    chk("t1_done", 32'(done), 1);
    chk("t1_blocked", 32'(bus.s_axis_tready), 0);
    chk("t1_itr", 32'(itr_count), 3);
    chk("t1_beats", 32'(beat_count), 12);
    tick();
    chk("t1_done_once", 32'(done), 0);
    quiet();
    tick();

    // same layer with the engine ready every other cycle
    send_cmd(3);
    nb = 0; ncfg = 0;
    for (int c = 0; c < 100 && nb < 12; c++) begin
      bus.s_axis_tvalid = 1;
      bus.m_axis_tready = c[0];
      bus.s_axis_tlast  = (nb % 4 == 3);
      bus.s_axis_is_cfg = 1'($urandom);
      if (bus.m_axis_tready) begin
        nb++;
        if (bus.s_axis_is_cfg) ncfg++;
      end
      tick();
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_itr", 32'(itr_count), 3);
    chk("t2_beats", 32'(beat_count), 12);
    chk("t2_cfg", 32'(cfg_count), ncfg);
    tick();
    quiet();

    // zero-iteration layer completes without opening the gate
    send_cmd(0);
    bus.s_axis_tvalid = 1;
    bus.m_axis_tready = 1;
    chk("t3_done", 32'(done), 1);
    chk("t3_gate", 32'(bus.m_axis_tvalid), 0);
    tick();
    chk("t3_done_once", 32'(done), 0);
    chk("t3_beats", 32'(beat_count), 0);
    quiet();

    // watchdog: no beats for TIMEOUT RUN cycles
    send_cmd(2);
    repeat (TIMEOUT - 1) tick();
    chk("t4_not_yet", 32'(err_timeout), 0);
    chk("t4_still_busy", 32'(busy), 1);
    tick();
    chk("t4_err", 32'(err_timeout), 1);
    chk("t4_no_done", 32'(done), 0);
    tick();
    chk("t4_idle", 32'(busy), 0);
    chk("t4_sticky", 32'(err_timeout), 1);
    send_cmd(1);
    chk("t4_cleared", 32'(err_timeout), 0);
    bus.s_axis_tvalid = 1; bus.m_axis_tready = 1; bus.s_axis_tlast = 1;
    tick();
    quiet();
    tick();

    // abort coinciding with the final tlast beat
    send_cmd(1);
    bus.s_axis_tvalid = 1; bus.m_axis_tready = 1;
    tick();
    bus.s_axis_tlast = 1;
    abort = 1;
    tick();
    abort = 0;
    chk("t5_idle", 32'(busy), 0);
    chk("t5_no_done", 32'(done), 0);
    chk("t5_itr", 32'(itr_count), 1);
    chk("t5_beats", 32'(beat_count), 2);
    quiet();
    tick();

    // reset in the middle of a layer
    send_cmd(3);
    bus.s_axis_tvalid = 1; bus.m_axis_tready = 1;
    repeat (5) tick();
    areset = 1;
    tick();
    areset = 0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_beats", 32'(beat_count), 0);
    chk("t6_cmd_ready", 32'(bus.s_cmd_ready), 1);
    chk("t6_gate", 32'(bus.m_axis_tvalid), 0);
    quiet();

    // randomized traffic at falling stream densities
    for (int i = 0; i < 4000; i++) begin
      dens = 4 - i / 1000;
      areset            = ($urandom_range(299) == 0);
      bus.s_cmd_valid   = ($urandom_range(3) == 0);
      bus.s_cmd_itr     = ITR_W'($urandom_range(4));
      abort             = ($urandom_range(59) == 0);
      bus.s_axis_tvalid = ($urandom_range(3) < dens);
      bus.s_axis_tlast  = ($urandom_range(3) == 0);
      bus.s_axis_is_cfg = 1'($urandom);
      bus.m_axis_tready = ($urandom_range(3) < 2 + (dens > 2 ? 1 : 0));
      tick();
    end
    quiet();
    areset = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
